// File: rtl/vga_pkg.sv
// Shared VGA constants: phase codes, RGB18 packing and channel rotation.
package vga_pkg;

  typedef enum logic [2:0] {
    PH_BLANK    = 3'd0,
    PH_FADE_IN  = 3'd1,
    PH_HOLD     = 3'd2,
    PH_CYCLE    = 3'd3,
    PH_FADE_OUT = 3'd4
  } phase_e;

  typedef struct packed {
    logic [5:0] r;
    logic [5:0] g;
    logic [5:0] b;
  } rgb18_t;

  localparam logic [17:0] BG_INC_INIT = {6'd0, 6'd63, 6'd1};

  function automatic rgb18_t rgb_unpack(input logic [17:0] v);
    return rgb18_t'(v);
  endfunction

  function automatic logic [17:0] rgb_pack(input rgb18_t c);
    return {c.r, c.g, c.b};
  endfunction

  // {R,G,B} <- {G,B,R}
  function automatic rgb18_t rgb_rotate(input rgb18_t c);
    rgb18_t o;
    o.r = c.g;
    o.g = c.b;
    o.b = c.r;
    return o;
  endfunction

endpackage

// File: rtl/frame_edge_detect.sv
// Registered one-cycle pulse when vpos returns to line 0.
module frame_edge_detect #(
  parameter int W = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] vpos,
  output logic         tick
);

  logic [W-1:0] vpos_prv_q;
  logic         tick_q;
  logic         tick_d;

  always_comb begin
    tick_d = (vpos == '0) && (vpos_prv_q != '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vpos_prv_q <= '0;
      tick_q     <= 1'b0;
    end else begin
      vpos_prv_q <= vpos;
      tick_q     <= tick_d;
    end
  end

  assign tick = tick_q;

endmodule

// File: rtl/vga_anim_sequencer.sv
// Per-frame logo fade / background rotation sequencer.
module vga_anim_sequencer
  import vga_pkg::*;
#(
  parameter int LOGO_MAX     = 61,
  parameter int HOLD_FRAMES  = 120,
  parameter int CYCLE_FRAMES = 256,
  parameter int ROT_PERIOD   = 16,
  parameter int BLANK_FRAMES = 30
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [9:0]  vpos,
  input  logic        pause,
  input  logic        step,
  input  logic [1:0]  speed,
  output logic        frame_tick,
  output logic [10:0] frame,
  output logic [2:0]  phase,
  output logic [5:0]  logo_level,
  output logic [17:0] bg_inc,
  output logic        cfg_update
);

  localparam int FC_W = 9;
  localparam int RW   = $clog2(ROT_PERIOD);

  logic            tick;
  logic            step_prv_q, step_pend_q, step_pend_d;
  logic [10:0]     frame_q, frame_d;
  phase_e          phase_q, phase_d;
  logic [5:0]      level_q, level_d;
  logic [17:0]     bg_q, bg_d;
  logic [FC_W-1:0] fc_q, fc_d;
  logic            cfg_q, cfg_d;
  logic            adv;
  logic [6:0]      inc, sum;

  frame_edge_detect #(.W(10)) u_edge (
    .clk   (clk),
    .rst_n (rst_n),
    .vpos  (vpos),
    .tick  (tick)
  );

  always_comb begin
    adv         = tick & (~pause | step_pend_q);
    step_pend_d = pause & ((step_pend_q & ~tick) | (step & ~step_prv_q));
    frame_d     = frame_q + 11'(tick);
    inc         = 7'd1 << speed;
    sum         = {1'b0, level_q} + inc;
    phase_d     = phase_q;
    level_d     = level_q;
    bg_d        = bg_q;
    fc_d        = fc_q;
    cfg_d       = adv;
    if (adv) begin
      fc_d = fc_q + 1'b1;
      case (phase_q)
        PH_BLANK: begin
          level_d = '0;
          if (fc_q == FC_W'(BLANK_FRAMES - 1)) begin
            phase_d = PH_FADE_IN;
            fc_d    = '0;
          end
        end
        PH_FADE_IN: begin
          if (sum >= 7'(LOGO_MAX)) begin
            level_d = 6'(LOGO_MAX);
            phase_d = PH_HOLD;
            fc_d    = '0;
          end else begin
            level_d = sum[5:0];
          end
        end
        PH_HOLD: begin
          if (fc_q == FC_W'(HOLD_FRAMES - 1)) begin
            phase_d = PH_CYCLE;
            fc_d    = '0;
          end
        end
        PH_CYCLE: begin
          if (fc_q[RW-1:0] == RW'(ROT_PERIOD - 1))
            bg_d = rgb_pack(rgb_rotate(rgb_unpack(bg_q)));
          if (fc_q == FC_W'(CYCLE_FRAMES - 1)) begin
            phase_d = PH_FADE_OUT;
            fc_d    = '0;
          end
        end
        PH_FADE_OUT: begin
          if ({1'b0, level_q} > inc) begin
            level_d = level_q - inc[5:0];
          end else begin
            level_d = '0;
            phase_d = PH_BLANK;
            bg_d    = BG_INC_INIT;
            fc_d    = '0;
          end
        end
        default: begin
          level_d = '0;
          phase_d = PH_BLANK;
          fc_d    = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      step_prv_q  <= 1'b0;
      step_pend_q <= 1'b0;
      frame_q     <= '0;
      phase_q     <= PH_BLANK;
      level_q     <= '0;
      bg_q        <= BG_INC_INIT;
      fc_q        <= '0;
      cfg_q       <= 1'b0;
    end else begin
      step_prv_q  <= step;
      step_pend_q <= step_pend_d;
      frame_q     <= frame_d;
      phase_q     <= phase_d;
      level_q     <= level_d;
      bg_q        <= bg_d;
      fc_q        <= fc_d;
      cfg_q       <= cfg_d;
    end
  end

  assign frame_tick = tick;
  assign frame      = frame_q;
  assign phase      = phase_q;
  assign logo_level = level_q;
  assign bg_inc     = bg_q;
  assign cfg_update = cfg_q;

endmodule
